// File: rtl/snake_pkg.sv
// Shared constants and types for the board write scheduler.
// Cell codes, segment geometry and the frame FSM state encoding.
package snake_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_FOOD  = 2'b01;
   localparam logic [1:0] CELL_BODY  = 2'b10;
   localparam logic [1:0] CELL_HEAD  = 2'b11;

   localparam int SEG_W   = 8;
   localparam int SEG_MAX = 225;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SNAKE,
      FOOD,
      DONE
   } state_t;

endpackage

// File: rtl/cell_scan_counter.sv
// Row-major x/y cell scanner: x is the inner index, y the outer one.
// Ports: i_clk, i_rst (sync high), i_clr, i_adv; o_nx/o_ny next cell, o_last.
module cell_scan_counter #(
   parameter int GRID_DIM = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clr,
   input  logic       i_adv,
   output logic [3:0] o_nx,
   output logic [3:0] o_ny,
   output logic       o_last
);

   localparam logic [3:0] LAST = 4'(GRID_DIM - 1);

   logic [3:0] r_x;
   logic [3:0] r_y;
   logic       w_xlast;
   logic       w_ylast;

   assign w_xlast = (r_x == LAST);
   assign w_ylast = (r_y == LAST);
   assign o_last  = w_xlast & w_ylast;

   // Next cell wraps back to (0,0) after the final one.
   assign o_nx = w_xlast ? 4'd0 : r_x + 4'd1;
   assign o_ny = w_xlast ? (w_ylast ? 4'd0 : r_y + 4'd1) : r_y;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_x <= 4'd0;
         r_y <= 4'd0;
      end else if (i_adv) begin
         r_x <= o_nx;
         r_y <= o_ny;
      end
   end

endmodule

// File: rtl/board_write_sched.sv
// Renders one frame into board memory: clear all cells, draw snake, draw food.
// Ports: clk, reset, start, snake_in/len, food_x/y, wr_ready -> wr_en, x/y_loc, data_out, busy, done.
module board_write_sched #(
   parameter int GRID_DIM = 16,
   parameter int SEG_MAX  = 225
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [SEG_MAX*8-1:0] snake_in,
   input  logic [7:0]           snake_len,
   input  logic [3:0]           food_x,
   input  logic [3:0]           food_y,
   input  logic                 wr_ready,
   output logic                 wr_en,
   output logic [3:0]           x_loc,
   output logic [3:0]           y_loc,
   output logic [1:0]           data_out,
   output logic                 busy,
   output logic                 done
);

   import snake_pkg::*;

   state_t                   r_state;
   logic [SEG_MAX*SEG_W-1:0] r_snake;
   logic [7:0]               r_len;
   logic [7:0]               r_seg;
   logic [3:0]               r_fx;
   logic [3:0]               r_fy;
   logic                     r_wr_en;
   logic                     r_busy;
   logic                     r_done;
   logic [3:0]               r_x;
   logic [3:0]               r_y;
   logic [1:0]               r_data;

   logic                     w_acc;
   logic                     w_start;
   logic                     w_adv;
   logic [3:0]               w_nx;
   logic [3:0]               w_ny;
   logic                     w_last_cell;
   logic [7:0]               w_nseg;
   logic [SEG_W-1:0]         w_nword;
   logic                     w_last_seg;

   assign w_acc      = r_wr_en & wr_ready;
   assign w_start    = (r_state == IDLE) & start;
   assign w_adv      = (r_state == CLEAR) & w_acc;
   assign w_nseg     = r_seg + 8'd1;
   assign w_nword    = r_snake[w_nseg*SEG_W +: SEG_W];
   assign w_last_seg = (w_nseg == r_len);

   cell_scan_counter #(
      .GRID_DIM (GRID_DIM)
   ) u_scan (
      .i_clk  (clk),
      .i_rst  (reset),
      .i_clr  (w_start),
      .i_adv  (w_adv),
      .o_nx   (w_nx),
      .o_ny   (w_ny),
      .o_last (w_last_cell)
   );

   // Output registers always hold the write being offered; they only
   // move on an accepted write, so a stall keeps them stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_len   <= 8'd0;
         r_seg   <= 8'd0;
         r_fx    <= 4'd0;
         r_fy    <= 4'd0;
         r_wr_en <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_x     <= 4'd0;
         r_y     <= 4'd0;
         r_data  <= CELL_EMPTY;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_snake <= snake_in;
                  r_len   <= (snake_len > 8'(SEG_MAX)) ? 8'(SEG_MAX)
                                                       : snake_len;
                  r_fx    <= food_x;
                  r_fy    <= food_y;
                  r_seg   <= 8'd0;
                  r_wr_en <= 1'b1;
                  r_busy  <= 1'b1;
                  r_x     <= 4'd0;
                  r_y     <= 4'd0;
                  r_data  <= CELL_EMPTY;
                  r_state <= CLEAR;
               end
            end
            CLEAR: begin
               if (w_acc) begin
                  if (!w_last_cell) begin
                     r_x <= w_nx;
                     r_y <= w_ny;
                  end else if (r_len == 8'd0) begin
                     r_x     <= r_fx;
                     r_y     <= r_fy;
                     r_data  <= CELL_FOOD;
                     r_state <= FOOD;
                  end else begin
                     r_seg   <= 8'd0;
                     r_x     <= r_snake[3:0];
                     r_y     <= r_snake[7:4];
                     r_data  <= CELL_HEAD;
                     r_state <= SNAKE;
                  end
               end
            end
            SNAKE: begin
               if (w_acc) begin
                  if (w_last_seg) begin
                     r_x     <= r_fx;
                     r_y     <= r_fy;
                     r_data  <= CELL_FOOD;
                     r_state <= FOOD;
                  end else begin
                     r_seg  <= w_nseg;
                     r_x    <= w_nword[3:0];
                     r_y    <= w_nword[7:4];
                     r_data <= CELL_BODY;
                  end
               end
            end
            FOOD: begin
               if (w_acc) begin
                  r_wr_en <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign wr_en    = r_wr_en;
   assign x_loc    = r_x;
   assign y_loc    = r_y;
   assign data_out = r_data;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_board_write_sched.sv
// Self-checking bench for board_write_sched: vector table, corner sequences
// and random frames compared against a list-of-writes reference model.
module tb_board_write_sched;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic [1:0] d;
   } wr_t;

   typedef struct {
      int kind;
      int len;
      int fx;
      int fy;
      int rmode;
      bit chkt;
      bit disturb;
      int exp_wr;
      int exp_done;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1799:0] snake_in;
   logic [7:0]    snake_len;
   logic [3:0]    food_x;
   logic [3:0]    food_y;
   logic          wr_ready;
   logic          wr_en;
   logic [3:0]    x_loc;
   logic [3:0]    y_loc;
   logic [1:0]    data_out;
   logic          busy;
   logic          done;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  rmode   = 0;
   logic [7:0] segs [225];

   wr_t got_q[$];
   int  got_cyc_q[$];
   int  done_q[$];
   logic prev_stall = 1'b0;
   wr_t  prev_w;

   board_write_sched #(
      .GRID_DIM (16),
      .SEG_MAX  (225)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .snake_in  (snake_in),
      .snake_len (snake_len),
      .food_x    (food_x),
      .food_y    (food_y),
      .wr_ready  (wr_ready),
      .wr_en     (wr_en),
      .x_loc     (x_loc),
      .y_loc     (y_loc),
      .data_out  (data_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name,
                      input int act, input int exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // wr_ready pattern: 0 always high, 1 alternating, 2 random ~70%.
   initial begin
      wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            1:       wr_ready = ~wr_ready;
            2:       wr_ready = ($urandom_range(0, 9) < 7);
            default: wr_ready = 1'b1;
         endcase
      end
   end

   // Write monitor: log accepted writes, check stall stability.
   always @(negedge clk) begin
      if (!reset) begin
         if (prev_stall)
            chk(wr_en && ({x_loc, y_loc, data_out} == prev_w),
                "stall_stable", {wr_en, x_loc, y_loc, data_out},
                {1'b1, prev_w});
         if (wr_en && !busy)
            chk(1'b0, "busy_during_write", busy, 1);
         if (done && (wr_en || !busy))
            chk(1'b0, "done_flags", {wr_en, busy}, 1);
         if (wr_en && wr_ready) begin
            got_q.push_back({x_loc, y_loc, data_out});
            got_cyc_q.push_back(cyc);
         end
         if (done) done_q.push_back(cyc);
      end
      prev_stall <= wr_en && !wr_ready && !reset;
      prev_w     <= {x_loc, y_loc, data_out};
   end

   function automatic logic [1799:0] pack_segs();
      logic [1799:0] v;
      for (int i = 0; i < 225; i++) v[8*i +: 8] = segs[i];
      return v;
   endfunction

   task automatic fill_segs(input int kind);
      for (int i = 0; i < 225; i++) begin
         case (kind)
            0:       segs[i] = 8'h00;
            1:       segs[i] = 8'(i * 7 + 3);
            default: segs[i] = 8'($urandom);
         endcase
      end
      if (kind == 0) begin
         segs[0] = 8'h55;
         segs[1] = 8'h54;
         segs[2] = 8'h53;
      end
   endtask

   task automatic run_frame(input int len, input int fx, input int fy,
                            input int rm, input bit chkt,
                            input bit disturb, input int exp_wr,
                            input int exp_done, input string nm);
      wr_t exp_q[$];
      int  lc;
      int  t;
      int  k;
      int  bad;
      int  nmin;
      lc = (len > 225) ? 225 : len;
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            exp_q.push_back({4'(x), 4'(y), 2'b00});
      for (int i = 0; i < lc; i++)
         exp_q.push_back({segs[i][3:0], segs[i][7:4],
                          (i == 0) ? 2'b11 : 2'b10});
      exp_q.push_back({4'(fx), 4'(fy), 2'b01});
      rmode = rm;
      @(posedge clk);
      #1;
      got_q.delete();
      got_cyc_q.delete();
      done_q.delete();
      snake_in  = pack_segs();
      snake_len = 8'(len);
      food_x    = 4'(fx);
      food_y    = 4'(fy);
      start     = 1'b1;
      t         = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (disturb) begin
         repeat (20) @(posedge clk);
         #1;
         start    = 1'b1;
         snake_in = ~snake_in;
         food_x   = ~food_x;
         food_y   = ~food_y;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      k = 0;
      while (done_q.size() == 0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      repeat (12) @(negedge clk);
      rmode = 0;
      chk(done_q.size() == 1, {nm, "_done_count"}, done_q.size(), 1);
      chk(got_q.size() == exp_q.size(), {nm, "_model_count"},
          got_q.size(), exp_q.size());
      if (exp_wr >= 0)
         chk(got_q.size() == exp_wr, {nm, "_write_count"},
             got_q.size(), exp_wr);
      bad  = -1;
      nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++)
         if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
      if (bad >= 0)
         chk(1'b0, {nm, "_content"}, got_q[bad], exp_q[bad]);
      else
         chk(1'b1, {nm, "_content"}, 0, 0);
      if (chkt) begin
         chk(done_q.size() > 0 && done_q[0] - t == exp_done,
             {nm, "_done_time"}, (done_q.size() > 0) ? done_q[0] - t : -1,
             exp_done);
         chk(got_cyc_q.size() > 0 && got_cyc_q[0] - t == 1,
             {nm, "_first_write"},
             (got_cyc_q.size() > 0) ? got_cyc_q[0] - t : -1, 1);
      end
      chk(!busy && !wr_en, {nm, "_idle_after"}, {busy, wr_en}, 0);
   endtask

   vec_t vecs[8];

   initial begin
      int t;
      vecs[0] = '{0, 3,   9, 2, 0, 1, 0, 260, 261};
      vecs[1] = '{0, 3,   9, 2, 1, 0, 0, 260, -1};
      vecs[2] = '{1, 0,   7, 7, 0, 1, 0, 257, 258};
      vecs[3] = '{1, 250, 1, 14, 0, 1, 0, 482, 483};
      vecs[4] = '{1, 225, 15, 0, 2, 0, 0, 482, -1};
      vecs[5] = '{1, 1,   3, 3, 0, 1, 0, 258, 259};
      vecs[6] = '{1, 3,   4, 8, 0, 1, 1, 260, 261};
      vecs[7] = '{1, 255, 0, 0, 1, 0, 0, 482, -1};

      // Reset together with start: reset must win.
      reset     = 1'b1;
      start     = 1'b1;
      snake_in  = '0;
      snake_len = 8'd3;
      food_x    = 4'd0;
      food_y    = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({wr_en, busy, done, x_loc, y_loc, data_out} == 13'd0,
          "reset_state", {wr_en, busy, done, x_loc, y_loc, data_out}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk(!busy && !wr_en, "idle_no_start", {busy, wr_en}, 0);

      for (int v = 0; v < 8; v++) begin
         fill_segs(vecs[v].kind);
         run_frame(vecs[v].len, vecs[v].fx, vecs[v].fy, vecs[v].rmode,
                   vecs[v].chkt, vecs[v].disturb, vecs[v].exp_wr,
                   vecs[v].exp_done, $sformatf("vec%0d", v));
      end

      // Reset while segment 10 of the snake is being offered.
      fill_segs(1);
      rmode = 0;
      @(posedge clk);
      #1;
      snake_in  = pack_segs();
      snake_len = 8'd20;
      food_x    = 4'd2;
      food_y    = 4'd2;
      start     = 1'b1;
      t         = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (266) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk(wr_en && data_out == 2'b10 && {y_loc, x_loc} == segs[10],
          "seg10_offered", {wr_en, data_out, y_loc, x_loc},
          {1'b1, 2'b10, segs[10]});
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk({wr_en, busy, done, x_loc, y_loc, data_out} == 13'd0,
          "mid_reset", {wr_en, busy, done, x_loc, y_loc, data_out}, 0);
      fill_segs(2);
      run_frame(5, 11, 6, 0, 1, 0, 262, 263, "after_reset");

      // Random frames against the reference model.
      for (int r = 0; r < 6; r++) begin
         fill_segs(2);
         run_frame($urandom_range(0, 255), $urandom_range(0, 15),
                   $urandom_range(0, 15), 2, 0, 0, -1, -1,
                   $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
